// File: rtl/samples_mem_pkg.sv
// Shared types and constants for the sample/program RAM loader and arbiter.
package samples_mem_pkg;

  localparam int IOCTL_ADDR_W = 25;
  localparam int IOCTL_DATA_W = 8;

  // Image lifecycle: EMPTY (no image), LOAD (download window open),
  // DRAIN (window closed, last byte still buffered), READY (image valid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } state_t;

endpackage

// File: rtl/samples_mem_loader_arbiter_if.sv
// Bus bundle between the loader/arbiter and its parent: ioctl download path,
// CPU request/ack bus and the single RAM port.
//
// Handshake semantics:
//  - ioctl: ioctl_wr is a one-cycle strobe; the arbiter raises ioctl_wait the
//    cycle after it buffers a byte and keeps it high until that byte has been
//    sent to the RAM. The HPS must not strobe again while ioctl_wait is high.
//  - cpu: cpu_req (with cpu_we/cpu_addr/cpu_wdata) is held stable until
//    cpu_ack; cpu_ack is a one-cycle pulse and cpu_rdata is valid only with it.
//  - mem: mem_we/mem_rd are single-cycle strobes qualified by mem_addr;
//    mem_rdata holds read data from the clock edge after mem_rd.
interface samples_mem_loader_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) ();
  import samples_mem_pkg::*;

  logic                    ioctl_download;
  logic                    ioctl_wr;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [IOCTL_DATA_W-1:0] ioctl_data;
  logic                    ioctl_wait;

  logic                    cpu_req;
  logic                    cpu_we;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [DATA_WIDTH-1:0]   cpu_wdata;
  logic                    cpu_ack;
  logic [DATA_WIDTH-1:0]   cpu_rdata;

  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_we;
  logic                    mem_rd;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // Arbiter view.
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
    output ioctl_wait,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    output mem_addr, mem_wdata, mem_we, mem_rd,
    input  mem_rdata
  );

  // Parent view: HPS, CPU and RAM side.
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
    input  ioctl_wait,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_rd,
    output mem_rdata
  );

endinterface

// File: rtl/samples_ioctl_holding_reg.sv
// One-entry buffer for an ioctl download byte. A strobe is accepted only when
// enabled and empty; the entry stays full until the arbiter pops it, and the
// full flag doubles as the HPS stall (ioctl_wait).
module samples_ioctl_holding_reg
  import samples_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic                    enable,
  input  logic [IOCTL_ADDR_W-1:0] addr_in,
  input  logic [IOCTL_DATA_W-1:0] data_in,
  input  logic                    pop,
  output logic                    accept,
  output logic                    full,
  output logic [IOCTL_ADDR_W-1:0] addr,
  output logic [IOCTL_DATA_W-1:0] data,
  output logic                    stall
);

  // A strobe arriving while full is dropped; the HPS protocol never does it.
  assign accept = wr && enable && !full;
  assign stall  = full;

  // Capture on accept, release on pop; accept and pop are mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (accept) begin
      full <= 1'b1;
      addr <= addr_in;
      data <= data_in;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/samples_mem_loader_arbiter.sv
// Owns the single RAM port shared by the ioctl image download and the CPU.
// Buffers download bytes, stalls the HPS, tracks image length and overflow,
// and arbitrates CPU accesses (buffered download byte always wins).
// Optional feature: define SAMPLES_LOADER_CKSUM_EN to add load_cksum, the
// mod-256 sum of in-range bytes written during the current download.
module samples_mem_loader_arbiter
  import samples_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  samples_mem_loader_arbiter_if.slave   bus,
  output logic                          rom_loaded,
  output logic [ADDR_WIDTH:0]           img_len,
  output logic                          load_ovf,
`ifdef SAMPLES_LOADER_CKSUM_EN
  output logic [7:0]                    load_cksum,
`endif
  output state_t                        state
);

  state_t                  state_next;
  logic                    download_q;
  logic                    rise;
  logic                    cpu_window;
  logic                    hold_accept;
  logic                    hold_full;
  logic [IOCTL_ADDR_W-1:0] hold_addr;
  logic [IOCTL_DATA_W-1:0] hold_data;
  logic                    hold_stall;
  logic                    issue;
  logic                    in_range;
  logic                    grant;
  logic                    ack_q;
  logic                    rd_mem_q;
  logic [ADDR_WIDTH:0]     len_cand;
  logic [ADDR_WIDTH:0]     img_len_next;

  samples_ioctl_holding_reg u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr      (bus.ioctl_wr),
    .enable  (state == LOAD),
    .addr_in (bus.ioctl_addr),
    .data_in (bus.ioctl_data),
    .pop     (issue),
    .accept  (hold_accept),
    .full    (hold_full),
    .addr    (hold_addr),
    .data    (hold_data),
    .stall   (hold_stall)
  );

  assign rise       = bus.ioctl_download && !download_q;
  assign cpu_window = (state == EMPTY) || (state == READY);
  // A buffered byte is retired every cycle it is present; reset discards it.
  assign issue      = hold_full && !reset;
  assign in_range   = (hold_addr[IOCTL_ADDR_W-1:ADDR_WIDTH] == '0);
  assign len_cand   = {1'b0, hold_addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(1);
  // One CPU access in flight; the ack cycle itself never grants, and a
  // download rise in the same cycle pre-empts the CPU.
  assign grant      = !reset && bus.cpu_req && cpu_window && !rise && !ack_q && !hold_full;

  // Image length after this cycle's RAM write, used for the end-of-load decision.
  always_comb begin
    img_len_next = img_len;
    if (issue && in_range && (len_cand > img_len)) begin
      img_len_next = len_cand;
    end
  end

  // Next-state logic for the image lifecycle.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY, READY: begin
        if (rise) state_next = LOAD;
      end
      LOAD: begin
        if (!bus.ioctl_download) begin
          if (hold_accept) state_next = DRAIN;
          else             state_next = (img_len_next != '0) ? READY : EMPTY;
        end
      end
      DRAIN: begin
        // Entered with the last byte buffered; it is written this cycle.
        state_next = (img_len_next != '0) ? READY : EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // RAM port mux: buffered download byte first, then a granted CPU access.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_rd    = 1'b0;
    if (issue) begin
      bus.mem_addr  = hold_addr[ADDR_WIDTH-1:0];
      bus.mem_wdata = hold_data;
      bus.mem_we    = in_range;
    end else if (grant) begin
      bus.mem_addr = bus.cpu_addr;
      if (bus.cpu_we) begin
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = 1'b1;
      end else if (state == READY) begin
        bus.mem_rd = 1'b1;
      end
    end
  end

  // Download edge detect, CPU ack pipeline, image length and overflow tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      download_q <= 1'b0;
      ack_q      <= 1'b0;
      rd_mem_q   <= 1'b0;
      img_len    <= '0;
      load_ovf   <= 1'b0;
    end else begin
      download_q <= bus.ioctl_download;
      ack_q      <= grant;
      rd_mem_q   <= bus.mem_rd;
      if (cpu_window && rise) begin
        img_len  <= '0;
        load_ovf <= 1'b0;
      end else begin
        img_len <= img_len_next;
        if (issue && !in_range) load_ovf <= 1'b1;
      end
    end
  end

`ifdef SAMPLES_LOADER_CKSUM_EN
  logic [7:0] cksum;

  // Running mod-256 sum of bytes actually written to RAM this download.
  always_ff @(posedge clk) begin
    if (reset) begin
      cksum <= '0;
    end else if (cpu_window && rise) begin
      cksum <= '0;
    end else if (issue && in_range) begin
      cksum <= cksum + hold_data;
    end
  end

  assign load_cksum = cksum;
`endif

  assign rom_loaded     = (state == READY);
  assign bus.ioctl_wait = hold_stall;
  assign bus.cpu_ack    = ack_q;
  assign bus.cpu_rdata  = rd_mem_q ? bus.mem_rdata : '0;

endmodule
